// File: rtl/sub_arbiter.sv
// Two-requester round-robin controller for a shared one-cycle registered subtracter.
// Latches the winner's operands, pulses the subtracter enable once, captures the
// difference and returns it to the granted requester with a one-cycle done pulse.
module sub_arbiter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic              borrow,
  output logic              sub_enable,
  output logic [DATA_W-1:0] sub_op1,
  output logic [DATA_W-1:0] sub_op2,
  input  logic [DATA_W-1:0] sub_result
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_sel;
  logic              r_last;
  logic              r_grant0;
  logic              r_grant1;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_result;
  logic              r_borrow;
  logic              r_enable;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;

  logic              w_any;
  logic              w_sel;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // Arbitration: a lone requester wins outright; on a tie the one not served last wins.
  assign w_any = req0 | req1;
  assign w_sel = (req0 && req1) ? ~r_last : ~req0;
  assign w_a   = w_sel ? a1 : a0;
  assign w_b   = w_sel ? b1 : b0;

  // Control FSM with registered outputs; reset drops everything, including the enable, at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_enable <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op1    <= w_a;
            r_op2    <= w_b;
            r_borrow <= (w_a < w_b);
            r_enable <= 1'b1;
            r_grant0 <= ~w_sel;
            r_grant1 <= w_sel;
            r_sel    <= w_sel;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_enable <= 1'b0;
          r_state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_result <= sub_result;
          r_done0  <= ~r_sel;
          r_done1  <= r_sel;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_done0  <= 1'b0;
          r_done1  <= 1'b0;
          r_grant0 <= 1'b0;
          r_grant1 <= 1'b0;
          r_last   <= r_sel;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant0     = r_grant0;
  assign grant1     = r_grant1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign result     = r_result;
  assign borrow     = r_borrow;
  assign sub_enable = r_enable;
  assign sub_op1    = r_op1;
  assign sub_op2    = r_op2;

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter with a behavioural model of the shared subtracter.
module tb_sub_arbiter;

  localparam int unsigned DATA_W = 16;

  logic              clock;
  logic              reset;
  logic              req0;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic              req1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic              grant0;
  logic              grant1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] result;
  logic              borrow;
  logic              sub_enable;
  logic [DATA_W-1:0] sub_op1;
  logic [DATA_W-1:0] sub_op2;
  logic [DATA_W-1:0] sub_result;

  int n_checks = 0;
  int n_pass   = 0;

  sub_arbiter #(.DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .a0         (a0),
    .b0         (b0),
    .req1       (req1),
    .a1         (a1),
    .b1         (b1),
    .grant0     (grant0),
    .grant1     (grant1),
    .done0      (done0),
    .done1      (done1),
    .result     (result),
    .borrow     (borrow),
    .sub_enable (sub_enable),
    .sub_op1    (sub_op1),
    .sub_op2    (sub_op2),
    .sub_result (sub_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared subtracter: result register updates on an enabled rising edge only.
  initial sub_result = '0;
  always @(posedge clock) begin
    if (sub_enable) sub_result <= sub_op1 - sub_op2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " grant0"}, 32'(grant0), 32'd0);
    check({tag, " grant1"}, 32'(grant1), 32'd0);
    check({tag, " done0"}, 32'(done0), 32'd0);
    check({tag, " done1"}, 32'(done1), 32'd0);
    check({tag, " sub_enable"}, 32'(sub_enable), 32'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One isolated operation for a single requester; optionally perturbs the minuend after grant.
  task automatic single_op(input string tag, input logic sel,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [DATA_W-1:0] exp_res, input logic exp_borrow,
                           input logic perturb);
    if (sel) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    tick();  // E0
    check({tag, " E0 grant0"}, 32'(grant0), 32'(!sel));
    check({tag, " E0 grant1"}, 32'(grant1), 32'(sel));
    check({tag, " E0 sub_enable"}, 32'(sub_enable), 32'd1);
    check({tag, " E0 sub_op1"}, 32'(sub_op1), 32'(a));
    check({tag, " E0 sub_op2"}, 32'(sub_op2), 32'(b));
    if (perturb) begin
      if (sel) a1 = 16'd50; else a0 = 16'd50;
    end
    tick();  // E1
    check({tag, " E1 sub_enable"}, 32'(sub_enable), 32'd0);
    check({tag, " E1 done"}, 32'({done1, done0}), 32'd0);
    check({tag, " E1 sub_op1"}, 32'(sub_op1), 32'(a));
    tick();  // E2
    check({tag, " E2 done0"}, 32'(done0), 32'(!sel));
    check({tag, " E2 done1"}, 32'(done1), 32'(sel));
    check({tag, " E2 result"}, 32'(result), 32'(exp_res));
    check({tag, " E2 borrow"}, 32'(borrow), 32'(exp_borrow));
    check({tag, " E2 sub_op1"}, 32'(sub_op1), 32'(a));
    req0 = 1'b0;
    req1 = 1'b0;
    tick();  // E3
    check_idle_outputs({tag, " E3"});
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset result", 32'(result), 32'd0);
    check("reset borrow", 32'(borrow), 32'd0);
    check("reset sub_op1", 32'(sub_op1), 32'd0);
    check("reset sub_op2", 32'(sub_op2), 32'd0);
    reset = 1'b1;
    tick();
    check_idle_outputs("idle");

    single_op("r0 10-3", 1'b0, 16'd10, 16'd3, 16'd7, 1'b0, 1'b0);
    single_op("r1 3-5", 1'b1, 16'd3, 16'd5, 16'hFFFE, 1'b1, 1'b0);
    single_op("r1 max-max", 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    single_op("r0 perturb", 1'b0, 16'd10, 16'd3, 16'd7, 1'b0, 1'b1);

    // Fresh reset, then both requesters held for four operations: 0,1,0,1 every 4 clocks.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req0 = 1'b1; a0 = 16'd20; b0 = 16'd1;
    req1 = 1'b1; a1 = 16'd9;  b1 = 16'd4;
    for (int n = 0; n < 16; n++) begin
      automatic int   phase = n % 4;
      automatic logic s     = logic'((n / 4) % 2);
      tick();
      check($sformatf("rr n%0d grant0", n), 32'(grant0), 32'(phase < 3 && !s));
      check($sformatf("rr n%0d grant1", n), 32'(grant1), 32'(phase < 3 && s));
      check($sformatf("rr n%0d done0", n), 32'(done0), 32'(phase == 2 && !s));
      check($sformatf("rr n%0d done1", n), 32'(done1), 32'(phase == 2 && s));
      check($sformatf("rr n%0d sub_enable", n), 32'(sub_enable), 32'(phase == 0));
      if (phase == 2) begin
        check($sformatf("rr n%0d result", n), 32'(result), s ? 32'd5 : 32'd19);
        check($sformatf("rr n%0d borrow", n), 32'(borrow), 32'd0);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();

    // Reset pulled during EXEC: outputs clear immediately and no done follows.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    req0 = 1'b1; a0 = 16'd10; b0 = 16'd3;
    tick();  // E0
    check("mid grant0 before reset", 32'(grant0), 32'd1);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid async");
    check("mid async sub_op1", 32'(sub_op1), 32'd0);
    check("mid async sub_op2", 32'(sub_op2), 32'd0);
    check("mid async result", 32'(result), 32'd0);
    check("mid async borrow", 32'(borrow), 32'd0);
    req1 = 1'b1; a1 = 16'd9; b1 = 16'd4;
    tick();
    check_idle_outputs("mid held");
    reset = 1'b1;
    tick();  // E0 after release, tie goes to requester 0
    check("post grant0", 32'(grant0), 32'd1);
    check("post grant1", 32'(grant1), 32'd0);
    check("post sub_op1", 32'(sub_op1), 32'd10);
    tick();
    tick();
    check("post done0", 32'(done0), 32'd1);
    check("post done1", 32'(done1), 32'd0);
    check("post result", 32'(result), 32'd7);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
Two-requester round-robin controller that shares the single registered subtracter unit (one-cycle, enable-gated, posedge-registered result) between two datapath clients, e.g. ALU issue and address-offset logic. It latches the winning requester's operands and drives the subtracter's enable and operand inputs. It then captures the subtracter result and returns it with a one-cycle done pulse to the granted requester.

Parameters:
DATA_W, 16, operand/result width; must match the `DATA_WIDTH range of the shared subtracter.

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
req0  input  1  requester 0 operation request; held high until done0
a0  input  DATA_W  requester 0 minuend
b0  input  DATA_W  requester 0 subtrahend
req1  input  1  requester 1 operation request; held high until done1
a1  input  DATA_W  requester 1 minuend
b1  input  DATA_W  requester 1 subtrahend
grant0  output  1  requester 0 owns the subtracter
grant1  output  1  requester 1 owns the subtracter
done0  output  1  one-cycle pulse, result valid for requester 0
done1  output  1  one-cycle pulse, result valid for requester 1
result  output  DATA_W  difference, valid while done0/done1 high
borrow  output  1  1 when minuend < subtrahend (unsigned), valid with done
sub_enable  output  1  to subtracter enable
sub_op1  output  DATA_W  to subtracter op1
sub_op2  output  DATA_W  to subtracter op2
sub_result  input  DATA_W  from subtracter result

Behaviour:
- Reset (reset==0, async): state=IDLE; grant0/1=0, done0/1=0, sub_enable=0, sub_op1/op2=0, result=0, borrow=0; last_served=1, so requester 0 wins the first tie.
- States: IDLE, EXEC, CAPTURE, RESP. All outputs are registered.
- IDLE: if no req, stay. If exactly one req, select it. If both, select the requester != last_served.
  - Edge E0: latch the selected a/b into sub_op1/sub_op2, compute borrow from them, sub_enable<=1, grant_sel<=1, ->EXEC.
- EXEC: the subtracter samples enable=1 at edge E1. Controller sets sub_enable<=0, ->CAPTURE.
- CAPTURE: edge E2: result<=sub_result, done_sel<=1, ->RESP.
- RESP: edge E3: done_sel<=0, grant_sel<=0, last_served<=sel, ->IDLE.
- Timing:
  - Latency: req sampled at E0, done high in the cycle after E2 (3 clocks).
  - One operation per 4 clocks.
  - A request still held after RESP is re-arbitrated at E4, no earlier.
- Operands are sampled only at E0. Later changes to a*/b* are ignored until the next grant.
- sub_op1/sub_op2 stay stable from E0 through RESP.
- Arithmetic: result = (a − b) mod 2^DATA_W. borrow = (a < b) unsigned. No saturation.
- A req dropped after grant does not abort the operation: done still pulses and the result is discarded by the requester.
- The arbiter never asserts grant0 and grant1 together. Same for done0/done1, and at most one done per grant.
- Reset asserted mid-operation (any state): immediate return to reset values, no done pulse, and the subtracter enable drops at once. The subtracter's own result register is not cleared by this block.
- sub_enable is high for exactly one cycle per operation.

Test Plan:
- Reset then req0=1, a0=10, b0=3 -> grant0 high after E0, sub_enable high 1 cycle, done0 pulse 1 cycle after E2 with result=7, borrow=0; grant1/done1 never high.
- req1=1, a1=3, b1=5 (DATA_W=16) -> done1 with result=0xFFFE, borrow=1; a1=0xFFFF, b1=0xFFFF -> result=0, borrow=0.
- req0 and req1 rise on the same edge after reset (a0=20, b0=1; a1=9, b1=4) -> requester 0 served first (result 19), then requester 1 (result 5) starting 4 clocks later.
- Both reqs held continuously for 4 operations -> grants alternate 0,1,0,1. Each done is 4 clocks apart; grants never overlap.
- Change a0 from 10 to 50 the cycle after grant0 -> result still 7; sub_op1 stays 10 until RESP ends.
- Assert reset low during EXEC -> all outputs 0 within the same cycle, no done pulse. After release, req0 is served first.
